// File: rtl/store_monitor_if.sv
// Store-bus / store-log interface for store_monitor.
// slave  : monitor side (consumes the CPU store strobe, produces log and verdict).
// master : CPU / testbench side.
interface store_monitor_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        log_rd;
    logic        log_valid;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic        log_ovf;
    logic [15:0] store_cnt;
    logic        done;
    logic        pass;
    logic        fail;

    modport slave (
        input  MemWrite, DataAdr, WriteData, log_rd,
        output log_valid, log_adr, log_data, log_ovf, store_cnt, done, pass, fail
    );

    modport master (
        output MemWrite, DataAdr, WriteData, log_rd,
        input  log_valid, log_adr, log_data, log_ovf, store_cnt, done, pass, fail
    );
endinterface

// File: rtl/store_monitor.sv
// store_monitor: watches the CPU data-memory store port, logs every store into a
// show-ahead FIFO, counts stores (saturating) and issues a sticky PASS/FAIL verdict.
// Optional watchdog: define STORE_MONITOR_TIMEOUT_EN to force FAIL if no verdict is
// reached within TIMEOUT_CYC cycles of reset release.
module store_monitor #(
    parameter logic [31:0] PASS_ADDR    = 32'd100,
    parameter logic [31:0] PASS_VALUE   = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd96,
    parameter int          FIFO_DEPTH   = 8,
    parameter int unsigned TIMEOUT_CYC  = 32'd4096
) (
    input  logic            clk,
    input  logic            reset,
    store_monitor_if.slave  bus
);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     store_cnt_q, store_cnt_d;

    logic            pass_hit_s;
    logic            fail_hit_s;
    logic            timeout_s;
    logic            full_s;
    logic            nonempty_s;
    logic            pop_s;
    logic            push_s;

    // Decode the current store; address/data are ignored entirely while MemWrite is low.
    always_comb begin
        pass_hit_s = 1'b0;
        fail_hit_s = 1'b0;
        if (bus.MemWrite) begin
            pass_hit_s = (bus.DataAdr == PASS_ADDR) && (bus.WriteData == PASS_VALUE);
            fail_hit_s = (bus.DataAdr != SCRATCH_ADDR) && !pass_hit_s;
        end else begin
            pass_hit_s = 1'b0;
            fail_hit_s = 1'b0;
        end
    end

`ifdef STORE_MONITOR_TIMEOUT_EN
    logic [31:0] cyc_q, cyc_d;

    // Watchdog counter: runs from reset release and freezes once a verdict exists.
    always_comb begin
        if (state_q == ST_RUN) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end
        timeout_s = (cyc_q >= TIMEOUT_CYC);
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYC;
    assign timeout_s        = 1'b0;
`endif

    // Verdict FSM next state: RUN resolves once, PASS/FAIL hold until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (pass_hit_s) begin
                    state_d = ST_PASS;
                end else if (fail_hit_s || timeout_s) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PASS: state_d = ST_PASS;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_FAIL;  // illegal encoding fails safe
        endcase
    end

    // Store log and counter next state; a pop frees a slot for a same-cycle push.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        store_cnt_d = store_cnt_q;
        full_s      = (count_q == DEPTH_C);
        nonempty_s  = (count_q != {(AW+1){1'b0}});
        pop_s       = bus.log_rd && nonempty_s;
        push_s      = bus.MemWrite && (!full_s || pop_s);
        ovf_d       = ovf_q || (bus.MemWrite && full_s && !pop_s);

        if (push_s) begin
            mem_d[wr_ptr_q].adr  = bus.DataAdr;
            mem_d[wr_ptr_q].data = bus.WriteData;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.MemWrite && (store_cnt_q != 16'hFFFF)) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end else begin
            store_cnt_d = store_cnt_q;
        end
    end

    // State, log and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {(AW+1){1'b0}};
            ovf_q       <= 1'b0;
            store_cnt_q <= 16'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '{adr: 32'd0, data: 32'd0};
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            store_cnt_q <= store_cnt_d;
            mem_q       <= mem_d;
        end
    end

    // Outputs come straight from registers; the log head reads as zero when empty.
    assign bus.pass      = (state_q == ST_PASS);
    assign bus.fail      = (state_q == ST_FAIL);
    assign bus.done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign bus.log_valid = nonempty_s;
    assign bus.log_adr   = nonempty_s ? mem_q[rd_ptr_q].adr  : 32'd0;
    assign bus.log_data  = nonempty_s ? mem_q[rd_ptr_q].data : 32'd0;
    assign bus.log_ovf   = ovf_q;
    assign bus.store_cnt = store_cnt_q;
endmodule

// File: tb/tb_store_monitor.sv
// Directed, table-driven testbench for store_monitor (FIFO_DEPTH 8, TIMEOUT_CYC 50).
module tb_store_monitor;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    store_monitor_if bus ();

    store_monitor #(
        .PASS_ADDR    (32'd100),
        .PASS_VALUE   (32'd7),
        .SCRATCH_ADDR (32'd96),
        .FIFO_DEPTH   (8),
        .TIMEOUT_CYC  (32'd50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] data;
        logic        rd;
        logic        e_pass;
        logic        e_fail;
        logic        e_valid;
        logic [31:0] e_adr;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] data, input logic rd);
        bus.MemWrite  = mw;
        bus.DataAdr   = adr;
        bus.WriteData = data;
        bus.log_rd    = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        bus.MemWrite = 1'b0;
        bus.log_rd   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'd0;
        bus.WriteData = 32'd0;
        bus.log_rd    = 1'b0;

        //           mw    adr      data         rd    pass  fail  vld   head adr head data cnt    ovf
        tbl[0] = '{1'b1, 32'd96,  32'd5,        1'b0, 1'b0, 1'b0, 1'b1, 32'd96,  32'd5, 16'd1, 1'b0};
        tbl[1] = '{1'b0, 32'hx,   32'hx,        1'b0, 1'b0, 1'b0, 1'b1, 32'd96,  32'd5, 16'd1, 1'b0};
        tbl[2] = '{1'b1, 32'd100, 32'd7,        1'b1, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 16'd2, 1'b0};
        tbl[3] = '{1'b1, 32'd104, 32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 16'd3, 1'b0};
        tbl[4] = '{1'b0, 32'd0,   32'd0,        1'b1, 1'b1, 1'b0, 1'b1, 32'd104, 32'd0, 16'd3, 1'b0};
        tbl[5] = '{1'b0, 32'd0,   32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0, 16'd3, 1'b0};
        tbl[6] = '{1'b0, 32'd0,   32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0, 16'd3, 1'b0};
        tbl[7] = '{1'b1, 32'd8,   32'd9,        1'b1, 1'b1, 1'b0, 1'b1, 32'd8,   32'd9, 16'd4, 1'b0};

        // Reset state
        do_reset();
        #1;
        chk("rst_pass",  {31'd0, bus.pass},      32'd0);
        chk("rst_fail",  {31'd0, bus.fail},      32'd0);
        chk("rst_done",  {31'd0, bus.done},      32'd0);
        chk("rst_valid", {31'd0, bus.log_valid}, 32'd0);
        chk("rst_cnt",   {16'd0, bus.store_cnt}, 32'd0);

        // Table: scratch store, X inputs while idle, PASS, post-verdict logging, empty reads
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].mw, tbl[i].adr, tbl[i].data, tbl[i].rd);
            chk($sformatf("v%0d_pass", i),  {31'd0, bus.pass},      {31'd0, tbl[i].e_pass});
            chk($sformatf("v%0d_fail", i),  {31'd0, bus.fail},      {31'd0, tbl[i].e_fail});
            chk($sformatf("v%0d_done", i),  {31'd0, bus.done},      {31'd0, tbl[i].e_pass | tbl[i].e_fail});
            chk($sformatf("v%0d_valid", i), {31'd0, bus.log_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_adr", i),   bus.log_adr,            tbl[i].e_adr);
            chk($sformatf("v%0d_data", i),  bus.log_data,           tbl[i].e_data);
            chk($sformatf("v%0d_cnt", i),   {16'd0, bus.store_cnt}, {16'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_ovf", i),   {31'd0, bus.log_ovf},   {31'd0, tbl[i].e_ovf});
        end

        // PASS_ADDR with wrong data fails, and a later correct store cannot turn it into PASS
        do_reset();
        step(1'b1, 32'd100, 32'd6, 1'b0);
        chk("wrong_fail", {31'd0, bus.fail}, 32'd1);
        chk("wrong_pass", {31'd0, bus.pass}, 32'd0);
        chk("wrong_done", {31'd0, bus.done}, 32'd1);
        step(1'b1, 32'd100, 32'd7, 1'b0);
        chk("sticky_fail", {31'd0, bus.fail}, 32'd1);
        chk("sticky_pass", {31'd0, bus.pass}, 32'd0);

        // Store outside allowed addresses fails and is still logged
        do_reset();
        step(1'b1, 32'd104, 32'd0, 1'b0);
        chk("out_fail",  {31'd0, bus.fail},      32'd1);
        chk("out_valid", {31'd0, bus.log_valid}, 32'd1);
        chk("out_adr",   bus.log_adr,            32'd104);
        chk("out_data",  bus.log_data,           32'd0);

        // Overflow: nine scratch stores with no reads drop the ninth
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 32'd96, i, 1'b0);
        chk("ovf_flag", {31'd0, bus.log_ovf},   32'd1);
        chk("ovf_cnt",  {16'd0, bus.store_cnt}, 32'd9);
        chk("ovf_fail", {31'd0, bus.fail},      32'd0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("ovf_head%0d_valid", j), {31'd0, bus.log_valid}, 32'd1);
            chk($sformatf("ovf_head%0d_data", j),  bus.log_data,            j);
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("ovf_drained", {31'd0, bus.log_valid}, 32'd0);

        // Full log with simultaneous read and store: both happen, no overflow
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'd96, i, 1'b0);
        step(1'b1, 32'd96, 32'd8, 1'b1);
        chk("fullrw_ovf",  {31'd0, bus.log_ovf},   32'd0);
        chk("fullrw_cnt",  {16'd0, bus.store_cnt}, 32'd9);
        for (int j = 1; j < 9; j++) begin
            chk($sformatf("fullrw_head%0d", j), bus.log_data, j);
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("fullrw_drained", {31'd0, bus.log_valid}, 32'd0);

        // Asynchronous reset mid-run clears everything immediately
        do_reset();
        step(1'b1, 32'd96,  32'd1, 1'b0);
        step(1'b1, 32'd96,  32'd2, 1'b0);
        step(1'b1, 32'd104, 32'd3, 1'b0);
        chk("pre_rst_cnt",  {16'd0, bus.store_cnt}, 32'd3);
        chk("pre_rst_fail", {31'd0, bus.fail},      32'd1);
        bus.MemWrite = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pass",  {31'd0, bus.pass},      32'd0);
        chk("arst_fail",  {31'd0, bus.fail},      32'd0);
        chk("arst_done",  {31'd0, bus.done},      32'd0);
        chk("arst_valid", {31'd0, bus.log_valid}, 32'd0);
        chk("arst_adr",   bus.log_adr,            32'd0);
        chk("arst_data",  bus.log_data,           32'd0);
        chk("arst_ovf",   {31'd0, bus.log_ovf},   32'd0);
        chk("arst_cnt",   {16'd0, bus.store_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("post_rst_valid", {31'd0, bus.log_valid}, 32'd0);
        chk("post_rst_cnt",   {16'd0, bus.store_cnt}, 32'd0);

        // Watchdog behaviour with no stores
        do_reset();
`ifdef STORE_MONITOR_TIMEOUT_EN
        for (int c = 0; c < 50; c++) step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("to_fail_c50", {31'd0, bus.fail}, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("to_fail_c51", {31'd0, bus.fail}, 32'd1);
        chk("to_done_c51", {31'd0, bus.done}, 32'd1);
`else
        for (int c = 0; c < 1000; c++) step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("nto_fail_c1000", {31'd0, bus.fail}, 32'd0);
        chk("nto_done_c1000", {31'd0, bus.done}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
